// File: rtl/count_sequencer_if.sv
// Command channel for count_sequencer: valid/ready handshake plus the
// START-time configuration (target, mode, prescale).
interface count_sequencer_if #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PRESCALE_W = 4
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [WIDTH-1:0]      cmd_target;
  logic                  cmd_periodic;
  logic [PRESCALE_W-1:0] prescale;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_target,
    output cmd_periodic,
    output prescale,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_target,
    input  cmd_periodic,
    input  prescale,
    output cmd_ready
  );
endinterface

// File: rtl/count_sequencer.sv
// Command-driven sequencer for a prescaled, enable-gated up-counter.
// START/STOP/PAUSE/RESUME arrive over a valid/ready channel; completion is
// flagged when the count matches the programmed target (one-shot or periodic).
// Optional macro COUNT_SEQ_STICKY_IRQ_EN makes o_irq a sticky flag cleared by
// i_irq_clr; without it o_irq simply mirrors o_done.
module count_sequencer #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PRESCALE_W = 4
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  count_sequencer_if.slave   cmd,
  input  logic               i_irq_clr,
  output logic [WIDTH-1:0]   o_count,
  output logic [1:0]         o_state,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_irq,
  output logic               o_err
);

  localparam logic [1:0] StIdle   = 2'b00;
  localparam logic [1:0] StRun    = 2'b01;
  localparam logic [1:0] StPaused = 2'b10;

  localparam logic [1:0] OpStart  = 2'b00;
  localparam logic [1:0] OpStop   = 2'b01;
  localparam logic [1:0] OpPause  = 2'b10;
  localparam logic [1:0] OpResume = 2'b11;

  logic [1:0]            state_q, state_d;
  logic [WIDTH-1:0]      count_q, count_d;
  logic [WIDTH-1:0]      target_q, target_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic                  periodic_q, periodic_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  ready_en_q;

  logic tick;
  logic match_tick;
  logic accept;

  assign tick       = (state_q == StRun) && (presc_q == prescale_q);
  // Ready drops only while the terminal tick is being applied, so a command
  // can never race the completion update.
  assign match_tick = tick && (count_q == target_q);
  assign cmd.cmd_ready = ready_en_q && !match_tick;
  assign accept     = cmd.cmd_valid && cmd.cmd_ready;

  // Next-state: free-running count/prescale first, then an accepted command overrides.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    target_d   = target_q;
    presc_d    = presc_q;
    prescale_d = prescale_q;
    periodic_d = periodic_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    if (state_q == StRun) begin
      if (tick) begin
        presc_d = '0;
        if (count_q == target_q) begin
          done_d = 1'b1;
          if (periodic_q) begin
            count_d = '0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end

    if (accept) begin
      case (cmd.cmd_op)
        OpStart: begin
          target_d   = cmd.cmd_target;
          periodic_d = cmd.cmd_periodic;
          prescale_d = cmd.prescale;
          count_d    = '0;
          presc_d    = '0;
          state_d    = StRun;
          done_d     = 1'b0;
        end
        OpStop: begin
          state_d = StIdle;
          presc_d = '0;
          count_d = count_q;
        end
        OpPause: begin
          if (state_q == StRun) begin
            // Freeze exactly where we are; a tick landing this cycle is dropped.
            state_d = StPaused;
            count_d = count_q;
            presc_d = presc_q;
          end else begin
            err_d = 1'b1;
          end
        end
        OpResume: begin
          if (state_q == StPaused) begin
            state_d = StRun;
          end else begin
            err_d = 1'b1;
          end
        end
        default: begin
          err_d = 1'b0;
        end
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q    <= StIdle;
      count_q    <= '0;
      target_q   <= '0;
      presc_q    <= '0;
      prescale_q <= '0;
      periodic_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      target_q   <= target_d;
      presc_q    <= presc_d;
      prescale_q <= prescale_d;
      periodic_q <= periodic_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ready_en_q <= 1'b1;
    end
  end

  assign o_count = count_q;
  assign o_state = state_q;
  assign o_busy  = (state_q != StIdle);
  assign o_done  = done_q;
  assign o_err   = err_q;

`ifdef COUNT_SEQ_STICKY_IRQ_EN
  logic irq_q;

  // Sticky irq: set by a done pulse, cleared by i_irq_clr; a set in the clear cycle wins.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= done_q | (irq_q & ~i_irq_clr);
    end
  end

  // OR in done_q so irq is visible in the same cycle as the done pulse.
  assign o_irq = irq_q | done_q;
`else
  logic unused_irq_clr;
  assign unused_irq_clr = i_irq_clr;
  assign o_irq = done_q;
`endif

endmodule
